// File: rtl/alu_div_if.sv
// Request/response bundle between the control unit and the multi-cycle divider.
// The master issues operands on a start pulse. The slave returns results and flags with a done pulse.
interface alu_div_if #(
  parameter int WIDTH = 15
);
  logic             start;
  logic             s_div;
  logic [WIDTH:0]   a;
  logic [WIDTH:0]   b;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   q;
  logic [WIDTH:0]   r;
  logic             zero;
  logic             overflow;
  logic             div_zero;

  modport master (
    output start, s_div, a, b,
    input  busy, done, q, r, zero, overflow, div_zero
  );

  modport slave (
    input  start, s_div, a, b,
    output busy, done, q, r, zero, overflow, div_zero
  );
endinterface

// File: rtl/alu_div.sv
// Restoring shift/subtract divider that produces one quotient bit per clock, in signed or unsigned mode.
// Define ALU_DIV_EARLY_OUT_EN to finish at once when |a| < |b|.
module alu_div #(
  parameter int WIDTH = 15
) (
  input  logic      clk,
  input  logic      reset,
  alu_div_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [WIDTH:0] MIN_NEG = {1'b1, {WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH:0]  rem;
  logic [WIDTH:0]  quo;
  logic [WIDTH:0]  dvs;
  logic            sign_q;
  logic            sign_r;

  logic [WIDTH:0]   a_mag;
  logic [WIDTH:0]   b_mag;
  logic             ovf_case;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    a_mag    = bus.a;
    b_mag    = bus.b;
    if (bus.s_div && bus.a[WIDTH]) a_mag = -bus.a;
    if (bus.s_div && bus.b[WIDTH]) b_mag = -bus.b;
    ovf_case = bus.s_div && (bus.a == MIN_NEG) && (&bus.b);
    // The extra top bit of the trial difference acts as the borrow, i.e. "difference went negative".
    shifted  = {rem, quo[WIDTH]};
    trial    = shifted - {1'b0, dvs};
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together on the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.q        <= '0;
      bus.r        <= '0;
      bus.zero     <= 1'b0;
      bus.overflow <= 1'b0;
      bus.div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.q        <= '0;
            bus.r        <= '0;
            bus.zero     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.div_zero <= 1'b0;
            if (bus.b == '0) begin
              bus.q        <= '1;
              bus.r        <= bus.a;
              bus.div_zero <= 1'b1;
              state        <= DONE;
            end else if (ovf_case) begin
              bus.q        <= bus.a;
              bus.overflow <= 1'b1;
              state        <= DONE;
            end
`ifdef ALU_DIV_EARLY_OUT_EN
            else if (a_mag < b_mag) begin
              bus.r    <= bus.a;
              bus.zero <= 1'b1;
              state    <= DONE;
            end
`endif
            else begin
              rem      <= '0;
              quo      <= a_mag;
              dvs      <= b_mag;
              sign_q   <= bus.s_div & (bus.a[WIDTH] ^ bus.b[WIDTH]);
              sign_r   <= bus.s_div & bus.a[WIDTH];
              cnt      <= '0;
              bus.busy <= 1'b1;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          // quo doubles as the dividend shifter: the dividend bits leave at the top and the quotient bits enter at the bottom.
          if (!trial[WIDTH+1]) begin
            rem <= trial[WIDTH:0];
            quo <= {quo[WIDTH-1:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH:0];
            quo <= {quo[WIDTH-1:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH)) state <= FIX;
        end
        FIX: begin
          bus.q    <= sign_q ? -quo : quo;
          bus.r    <= sign_r ? -rem : rem;
          bus.zero <= (quo == '0);
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          // Fast paths arrive here with done low: they raise it for one cycle before leaving.
          if (!bus.done) begin
            bus.done <= 1'b1;
          end else begin
            bus.done <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_div.md
Name: alu_div

Overview:
- Multi-cycle integer divider: companion unit to the single-cycle ALU in the CPU datapath.
- Accepts operands `a` (dividend) and `b` (divisor) on a start pulse.
- Runs a restoring shift/subtract loop, one quotient bit per clock.
- Returns quotient, remainder and ALU-style flags with a done pulse; the control unit stalls the PC while busy.

Parameters:
- WIDTH, 15, MSB index of the operands (data width = WIDTH+1 bits, 16 by default).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  one-cycle request; sampled only in IDLE.
- s_div  input  1  1 = signed two's-complement division, 0 = unsigned.
- a  input  WIDTH+1  dividend, captured on accepted start.
- b  input  WIDTH+1  divisor, captured on accepted start.
- busy  output  1  high from the edge accepting start until the edge entering DONE.
- done  output  1  single-cycle pulse, results valid.
- q  output  WIDTH+1  quotient.
- r  output  WIDTH+1  remainder.
- zero  output  1  q == 0.
- overflow  output  1  signed (-2^WIDTH) / -1.
- div_zero  output  1  b == 0.

Behaviour:
- Reset (asynchronous, reset=0):
  - state = IDLE.
  - busy, done, q, r, zero, overflow, div_zero all 0.
  - Iteration counter 0.
  - An in-flight operation is discarded, and no done is produced after reset releases.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 at a rising edge E0 captures a, b and s_div.
  - Flags are cleared at E0.
  - Next state:
    - b == 0 -> DONE.
    - s_div & a == 2^WIDTH & b == all-ones -> DONE.
    - otherwise -> CALC, counter = 0, busy = 1.
  - In signed mode, operand magnitudes are taken at E0, and the result signs are stored: sign_q = a[MSB]^b[MSB], sign_r = a[MSB].
- CALC:
  - Each edge shifts the partial remainder left and brings in the next dividend bit.
  - It then subtracts the divisor magnitude and keeps the difference only if it is non-negative; the quotient bit = 1 if the difference was kept.
  - After WIDTH+1 iterations (edges E1..E(WIDTH+1)) -> FIX.
- FIX (edge E(WIDTH+2)):
  - Apply signs: q negated if sign_q, r negated if sign_r. Division truncates toward zero and the remainder takes the sign of the dividend.
  - Set zero.
  - Next state DONE; busy=0, done=1.
- DONE:
  - done high exactly one cycle.
  - Next edge -> IDLE.
  - start in DONE is ignored.
- Latency, normal path: done high in the cycle after edge E0+WIDTH+2 (17 edges for default width).
- Latency, fast paths: done high in the cycle after E1.
- Divide by zero: q = all ones, r = a, div_zero=1, overflow=0, zero=0.
- Signed overflow: q = 2^WIDTH (= a), r = 0, overflow=1.
- start while busy (CALC/FIX) or in DONE: ignored, with no queuing.
- q, r and the flags hold their values until the next accepted start (cleared at E0).
- Unsigned mode: operands are used as-is and sign handling is bypassed.

Optional Feature:
- Macro: ALU_DIV_EARLY_OUT_EN.
- Defined: in IDLE, if b != 0, no overflow case, and |a| < |b| (magnitudes per s_div):
  - Go directly to DONE with q=0, r=a, zero=1.
  - done is high in the cycle after E1.
- Undefined: such operands take the full CALC path, with identical results and normal latency.

Test Plan:
- Unsigned 100/7 -> q=14 (0x000E), r=2, zero=0, busy for 17 edges, done is a single pulse after edge 17.
- Signed -7/2 (a=0xFFF9, b=0x0002) -> q=0xFFFD, r=0xFFFF. Signed 7/-2 -> q=0xFFFD, r=0x0001.
- 5/0 (either mode) -> q=0xFFFF, r=0x0005, div_zero=1, done after 1 edge. Signed 0x8000/0xFFFF -> q=0x8000, r=0, overflow=1, done after 1 edge.
- Unsigned 3/7:
  - q=0, r=3, zero=1.
  - done after 1 edge with ALU_DIV_EARLY_OUT_EN, after 17 edges without.
- Start 100/7, pulse start with 50/5 at edge 5 -> ignored, result q=14, r=2.
- Assert reset low at edge 8 of an operation:
  - All outputs go to 0 immediately (asynchronously).
  - No done for 20 cycles after release.
  - A new 9/3 then returns q=3, r=0.
